ifid_hazard_ctrl: RTL

Fetch-side pipeline controller for the 5-stage MIPS core. It drives the PC register, the IF/ID latch and the ID/EX bubble insertion. It arbitrates between four conditions: branch redirect, load-use stall, jump redirect and instruction-memory wait states. It also keeps a saturating stall counter and a fetch-timeout watchdog. It sits beside the IF/ID latch and the PC mux; all datapath registers stay in their own modules.

---
 rtl/ifid_hazard_ctrl_pkg.sv | 20 ++
 rtl/ifid_hazard_ctrl_if.sv | 37 +++
 rtl/ifid_hazard_ctrl_lud.sv | 20 ++
 rtl/ifid_hazard_ctrl.sv | 115 +++++++++++
 4 files changed

// File: rtl/ifid_hazard_ctrl_pkg.sv
// Shared types and constants for the fetch-side hazard controller.
package ifid_ctrl_pkg;

    // Controller FSM states
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2,
        ERR  = 2'd3
    } state_e;

    // PC mux selects
    localparam logic [1:0] PCSEL_NPC = 2'b00;
    localparam logic [1:0] PCSEL_BR  = 2'b01;
    localparam logic [1:0] PCSEL_JMP = 2'b10;

    // $zero never carries a real dependency
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/ifid_hazard_ctrl_if.sv
// Pipeline-side signal bundle of the IF/ID hazard controller.
// master: the pipeline (drives hazard inputs), slave: the controller.
interface ifid_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             imem_ready;
    logic             idex_memread;
    logic [4:0]       idex_rt;
    logic [4:0]       ifid_rs;
    logic [4:0]       ifid_rt;
    logic             ifid_uses_rt;
    logic             jump;
    logic             branch_taken;

    logic             imem_req;
    logic             pc_write;
    logic [1:0]       pc_sel;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_bubble;
    logic [CNT_W-1:0] stall_cnt;
    logic             fetch_err;

    modport master (
        output imem_ready, idex_memread, idex_rt, ifid_rs, ifid_rt,
               ifid_uses_rt, jump, branch_taken,
        input  imem_req, pc_write, pc_sel, ifid_write, ifid_flush,
               idex_bubble, stall_cnt, fetch_err
    );

    modport slave (
        input  imem_ready, idex_memread, idex_rt, ifid_rs, ifid_rt,
               ifid_uses_rt, jump, branch_taken,
        output imem_req, pc_write, pc_sel, ifid_write, ifid_flush,
               idex_bubble, stall_cnt, fetch_err
    );
endinterface

// File: rtl/ifid_hazard_ctrl_lud.sv
// Load-use hazard compare between the load in EX and the instruction in ID.
module load_use_detect
    import ifid_ctrl_pkg::*;
(
    input  logic       idex_memread,
    input  logic [4:0] idex_rt,
    input  logic [4:0] ifid_rs,
    input  logic [4:0] ifid_rt,
    input  logic       ifid_uses_rt,
    output logic       hazard
);
    logic rs_hit, rt_hit;

    // rt only matters when the ID instruction actually reads it
    always_comb begin
        rs_hit = (idex_rt == ifid_rs);
        rt_hit = ifid_uses_rt && (idex_rt == ifid_rt);
        hazard = idex_memread && (idex_rt != REG_ZERO) && (rs_hit || rt_hit);
    end
endmodule

// File: rtl/ifid_hazard_ctrl.sv
// Fetch-side controller: PC enable/select, IF/ID write/flush, ID/EX bubble,
// saturating stall counter and fetch-timeout watchdog.
module ifid_hazard_ctrl
    import ifid_ctrl_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
)(
    input logic               clk,
    input logic               rst_n,
    ifid_hazard_ctrl_if.slave bus
);
    // Counter value at which the next not-ready WAIT cycle is the TIMEOUT-th
    // consecutive one (the RUN cycle that entered WAIT counts as the first).
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 2);

    state_e           state_q, state_d;
    logic [7:0]       wcnt_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             fetch_err_q;

    logic lu, active, jmp_eff, redirect, stall_evt;

    load_use_detect u_lud (
        .idex_memread (bus.idex_memread),
        .idex_rt      (bus.idex_rt),
        .ifid_rs      (bus.ifid_rs),
        .ifid_rt      (bus.ifid_rt),
        .ifid_uses_rt (bus.ifid_uses_rt),
        .hazard       (lu)
    );

    // Jump is suppressed under load-use; a branch always wins
    always_comb begin
        active   = (state_q == RUN) || (state_q == WAIT);
        jmp_eff  = bus.jump && !lu;
        redirect = bus.branch_taken || jmp_eff;
    end

    // Mealy output priority: branch > load-use > jump > imem wait > advance
    always_comb begin
        bus.imem_req    = 1'b0;
        bus.pc_write    = 1'b0;
        bus.pc_sel      = PCSEL_NPC;
        bus.ifid_write  = 1'b1;
        bus.ifid_flush  = 1'b0;
        bus.idex_bubble = 1'b0;
        stall_evt       = 1'b0;
        if (!active) begin
            bus.ifid_write  = 1'b0;
            bus.ifid_flush  = 1'b1;
            bus.idex_bubble = 1'b1;
        end else begin
            bus.imem_req = 1'b1;
            if (bus.branch_taken) begin
                bus.pc_sel      = PCSEL_BR;
                bus.pc_write    = 1'b1;
                bus.ifid_flush  = 1'b1;
                bus.idex_bubble = 1'b1;
            end else if (lu) begin
                bus.ifid_write  = 1'b0;
                bus.idex_bubble = 1'b1;
                stall_evt       = 1'b1;
            end else if (bus.jump) begin
                bus.pc_sel     = PCSEL_JMP;
                bus.pc_write   = 1'b1;
                bus.ifid_flush = 1'b1;
            end else if (!bus.imem_ready) begin
                bus.ifid_flush = 1'b1;
                stall_evt      = 1'b1;
            end else begin
                bus.pc_write = 1'b1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT: state_d = RUN;
            RUN:  if (!bus.imem_ready && !redirect) state_d = WAIT;
            WAIT: begin
                if (bus.imem_ready || redirect) state_d = RUN;
                else if (wcnt_q == WAIT_LAST)   state_d = ERR;
            end
            ERR:  state_d = ERR;
            default: state_d = BOOT;
        endcase
    end

    // State, wait counter, stall counter and sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= BOOT;
            wcnt_q      <= 8'd0;
            stall_cnt_q <= '0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == RUN || redirect)
                wcnt_q <= 8'd0;
            else if (state_q == WAIT && !bus.imem_ready)
                wcnt_q <= wcnt_q + 8'd1;
            if (stall_evt && stall_cnt_q != {CNT_W{1'b1}})
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (state_d == ERR)
                fetch_err_q <= 1'b1;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.fetch_err = fetch_err_q;

endmodule
